// File: rtl/rotator_arbiter.sv
// Two-port round-robin front end for a shared WIDTH-bit rotate unit.
// The accepted request is rotated and returned, registered, with its source tag.
module rotator_arbiter #(
  parameter int WIDTH = 4,
  parameter int SHW   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  input  logic [SHW-1:0]   req0_amt,
  input  logic             req0_dir,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  input  logic [SHW-1:0]   req1_amt,
  input  logic             req1_dir,
  output logic             req1_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  input  logic             out_ready,
  output logic             busy
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t           state, state_nx;
  logic             last_grant;
  logic             grant;
  logic             can_accept;
  logic             take;
  logic [WIDTH-1:0] sel_data;
  logic [SHW-1:0]   sel_amt;
  logic             sel_dir;
  logic [SHW-1:0]   k;
  logic [WIDTH-1:0] rotated;

  // A tie goes to the port that did not win the last transfer.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = ~last_grant;
    else if (req1_valid)          grant = 1'b1;
  end

  // Holding rst_n in the term keeps both readies low during reset.
  assign can_accept = rst_n && ((state == IDLE) || out_ready);
  assign req0_ready = can_accept && req0_valid && !grant;
  assign req1_ready = can_accept && req1_valid &&  grant;
  assign take       = req0_ready || req1_ready;

  assign sel_data = grant ? req1_data : req0_data;
  assign sel_amt  = grant ? req1_amt  : req0_amt;
  assign sel_dir  = grant ? req1_dir  : req0_dir;

  // Left by amt equals right by (WIDTH-amt) mod WIDTH; SHW-bit negation wraps.
  assign k = sel_dir ? -sel_amt : sel_amt;

  always_comb begin
    rotated = '0;
    for (int i = 0; i < WIDTH; i++) begin
      rotated[i] = sel_data[SHW'(i) + k];
    end
  end

  always_comb begin
    state_nx = state;
    if (take)                            state_nx = HOLD;
    else if (state == HOLD && out_ready) state_nx = IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      out_data   <= '0;
      out_src    <= 1'b0;
    end else begin
      state <= state_nx;
      if (take) begin
        out_data   <= rotated;
        out_src    <= grant;
        last_grant <= grant;
      end
    end
  end

  // Derived straight from the state register, so reset clears it without a clock edge.
  assign out_valid = (state == HOLD);
  assign busy      = (state == HOLD);

endmodule

// File: tb/tb_rotator_arbiter.sv
// Directed bench: stimulus pushes hand-computed results into a queue, and a
// monitor pops and compares each result the consumer accepts.
module tb_rotator_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [3:0] req0_data = '0, req1_data = '0;
  logic [1:0] req0_amt = '0, req1_amt = '0;
  logic       req0_dir = 1'b0, req1_dir = 1'b0;
  logic       req0_ready, req1_ready;
  logic       out_valid;
  logic [3:0] out_data;
  logic       out_src;
  logic       out_ready = 1'b0;
  logic       busy;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic       src;
    logic [3:0] data;
  } result_t;

  result_t exp_q[$];

  rotator_arbiter #(.WIDTH(4), .SHW(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_amt(req0_amt),
    .req0_dir(req0_dir), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_amt(req1_amt),
    .req1_dir(req1_dir), .req1_ready(req1_ready),
    .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
    .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // One clock cycle of stimulus: inputs change 2 units after the edge,
  // readies are checked 1 unit later against the hand-computed grant.
  task automatic cycle(input string name,
                       input logic v0, input logic [3:0] d0, input logic [1:0] a0, input logic r0,
                       input logic v1, input logic [3:0] d1, input logic [1:0] a1, input logic r1,
                       input logic ordy, input logic e_rdy0, input logic e_rdy1,
                       input logic [3:0] e_data);
    @(posedge clk);
    #2;
    req0_valid = v0; req0_data = d0; req0_amt = a0; req0_dir = r0;
    req1_valid = v1; req1_data = d1; req1_amt = a1; req1_dir = r1;
    out_ready  = ordy;
    #1;
    check({name, ".rdy0"}, req0_ready, e_rdy0);
    check({name, ".rdy1"}, req1_ready, e_rdy1);
    if (e_rdy0 || e_rdy1) exp_q.push_back('{src: e_rdy1, data: e_data});
  endtask

  task automatic idle(input string name, input logic ordy);
    cycle(name, 0, 4'h0, 2'd0, 0, 0, 4'h0, 2'd0, 0, ordy, 0, 0, 4'h0);
  endtask

  // Reset pulse placed between clock edges; any pending result is discarded.
  task automatic pulse_reset(input string name);
    @(posedge clk);
    #4;
    rst_n = 1'b0;
    #1;
    check({name, ".valid_async"}, out_valid, 0);
    check({name, ".busy_async"}, busy, 0);
    exp_q.delete();
    req0_valid = 0; req1_valid = 0; out_ready = 0;
    #2;
    rst_n = 1'b1;
  endtask

  // Monitor: a result is consumed at the next edge when valid and ready are both high.
  initial begin
    result_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("mon.unexpected_result", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("mon.data", out_data, e.data);
          check("mon.src", out_src, e.src);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset state, ready stays low even with a request pending
    req0_valid = 1'b1;
    #3;
    check("t1.valid_rst", out_valid, 0);
    check("t1.data_rst", out_data, 0);
    check("t1.rdy0_rst", req0_ready, 0);
    check("t1.busy_rst", busy, 0);
    req0_valid = 1'b0;
    #10;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) idle("t1.idle", 1);
    #1;
    check("t1.valid_idle", out_valid, 0);
    check("t1.data_idle", out_data, 0);
    check("t1.busy_idle", busy, 0);

    // 2/3: single-port rotations
    cycle("t2.r0", 1, 4'b1011, 2'd1, 0, 0, 4'h0, 2'd0, 0, 1, 1, 0, 4'b1101);
    #1;
    check("t2.valid_lat", out_valid, 0);
    @(posedge clk); #1;
    check("t2.valid_next", out_valid, 1);
    check("t2.busy_next", busy, 1);
    #1;
    req0_valid = 0;
    cycle("t3.l1", 0, 4'h0, 2'd0, 0, 1, 4'b1011, 2'd1, 1, 1, 0, 1, 4'b0111);
    cycle("t3.l0", 0, 4'h0, 2'd0, 0, 1, 4'b1011, 2'd0, 1, 1, 0, 1, 4'b1011);
    idle("t3.drain", 1);
    idle("t3.idle", 1);
    check("t3.empty", exp_q.size(), 0);

    // 4: both valid after reset alternate 0,1,0,1
    pulse_reset("t4");
    cycle("t4.a", 1, 4'b0001, 2'd1, 1, 1, 4'b1000, 2'd3, 0, 1, 1, 0, 4'b0010);
    cycle("t4.b", 1, 4'b0001, 2'd1, 1, 1, 4'b1000, 2'd3, 0, 1, 0, 1, 4'b0001);
    cycle("t4.c", 1, 4'b0001, 2'd1, 1, 1, 4'b1000, 2'd3, 0, 1, 1, 0, 4'b0010);
    cycle("t4.d", 1, 4'b0001, 2'd1, 1, 1, 4'b1000, 2'd3, 0, 1, 0, 1, 4'b0001);
    idle("t4.drain", 1);
    idle("t4.idle", 1);
    check("t4.empty", exp_q.size(), 0);

    // 5: stall with out_ready low, then back-to-back on release
    cycle("t5.load", 1, 4'b1100, 2'd2, 1, 0, 4'h0, 2'd0, 0, 1, 1, 0, 4'b0011);
    for (int i = 0; i < 3; i++) begin
      cycle("t5.stall", 1, 4'b0110, 2'd3, 0, 0, 4'h0, 2'd0, 0, 0, 0, 0, 4'h0);
      check("t5.hold_data", out_data, 4'b0011);
      check("t5.hold_valid", out_valid, 1);
    end
    cycle("t5.release", 1, 4'b0110, 2'd3, 0, 0, 4'h0, 2'd0, 0, 1, 1, 0, 4'b1100);
    idle("t5.drain", 1);
    check("t5.b2b_valid", out_valid, 1);
    check("t5.b2b_data", out_data, 4'b1100);
    idle("t5.idle", 1);
    check("t5.empty", exp_q.size(), 0);

    // 6: reset mid-HOLD drops valid at once; port 0 wins the first tie afterwards
    cycle("t6.load", 1, 4'b0001, 2'd0, 0, 0, 4'h0, 2'd0, 0, 0, 1, 0, 4'b0001);
    idle("t6.hold", 0);
    check("t6.held", out_valid, 1);
    pulse_reset("t6");
    cycle("t6.tie0", 1, 4'b0011, 2'd1, 0, 1, 4'b0101, 2'd1, 1, 1, 1, 0, 4'b1001);
    cycle("t6.tie1", 1, 4'b0011, 2'd1, 0, 1, 4'b0101, 2'd1, 1, 1, 0, 1, 4'b1010);
    idle("t6.drain", 1);
    idle("t6.idle", 1);
    check("t6.empty", exp_q.size(), 0);
    check("t6.final_valid", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
